// File: rtl/issue_sequencer.sv
// Issue sequencer between fetch and decode: scoreboard-based RAW stalls, memory-busy stalls
// and branch serialisation. Define ISSUE_STALL_COUNTER_EN to enable the stall-cycle counter.
module issue_sequencer #(
  parameter int unsigned NREG    = 16,
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned LD_LAT  = 3,
  parameter int unsigned CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  output logic        if_ready,
  output logic        id_valid,
  output logic [15:0] id_instr,
  input  logic        mem_busy,
  input  logic        ex_resolve,
  input  logic        ex_taken,
  output logic        flush,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpMul = 4'b0010;
  localparam logic [3:0] OpInc = 4'b0011;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpCmp = 4'b0110;
  localparam logic [3:0] OpSt  = 4'b1010;
  localparam logic [3:0] OpBeq = 4'b1011;
  localparam logic [3:0] OpRes = 4'b1100;
  localparam logic [3:0] OpLd  = 4'b1101;
  localparam logic [3:0] OpJmp = 4'b1111;

  typedef enum logic [1:0] {StRun, StBrWait, StFlush} state_e;

  state_e state_q;

  logic [3:0] op, rd, rs1, rs2;
  assign op  = if_instr[15:12];
  assign rd  = if_instr[11:8];
  assign rs1 = if_instr[7:4];
  assign rs2 = if_instr[3:0];

  logic             src_rs1, src_rs2, src_rd, src_flag;
  logic             wr_rd, wr_flag, is_mem, is_br;
  logic [CNT_W-1:0] wr_lat;

  always_comb begin
    src_rs1  = 1'b0;
    src_rs2  = 1'b0;
    src_rd   = 1'b0;
    src_flag = 1'b0;
    wr_rd    = 1'b0;
    wr_flag  = 1'b0;
    is_mem   = 1'b0;
    is_br    = 1'b0;
    wr_lat   = CNT_W'(ALU_LAT - 1);
    case (op)
      OpAdd, OpMul, OpXor: begin
        src_rs1 = 1'b1;
        src_rs2 = 1'b1;
        wr_rd   = 1'b1;
      end
      OpInc: begin
        src_rs1 = 1'b1;
        wr_rd   = 1'b1;
      end
      OpCmp: begin
        src_rs1 = 1'b1;
        src_rs2 = 1'b1;
        wr_flag = 1'b1;
      end
      OpLd: begin
        src_rs1 = 1'b1;
        wr_rd   = 1'b1;
        is_mem  = 1'b1;
        wr_lat  = CNT_W'(LD_LAT - 1);
      end
      OpRes: begin
        wr_rd  = 1'b1;
        wr_lat = CNT_W'(LD_LAT - 1);
      end
      OpSt: begin
        src_rd  = 1'b1;
        src_rs1 = 1'b1;
        is_mem  = 1'b1;
      end
      OpBeq: begin
        src_flag = 1'b1;
        is_br    = 1'b1;
      end
      OpJmp:   is_br = 1'b1;
      default: ;
    endcase
  end

  // Countdown scoreboard: nonzero means the result is not yet available to a dependent.
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] flag_cnt_q;
  logic             hazard, issue;

  always_comb begin
    hazard = (src_rs1  && (cnt_q[rs1] != '0)) ||
             (src_rs2  && (cnt_q[rs2] != '0)) ||
             (src_rd   && (cnt_q[rd]  != '0)) ||
             (src_flag && (flag_cnt_q != '0));
  end

  assign if_ready = (state_q == StRun) && !hazard && !(is_mem && mem_busy);
  assign issue    = if_valid && if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      flag_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (issue && wr_rd && (rd == 4'(i))) begin
          cnt_q[i] <= wr_lat;
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
      if (issue && wr_flag) begin
        flag_cnt_q <= wr_lat;
      end else if (flag_cnt_q != '0) begin
        flag_cnt_q <= flag_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      id_valid <= 1'b0;
      id_instr <= 16'h0000;
      flush    <= 1'b0;
    end else begin
      id_valid <= issue;
      id_instr <= issue ? if_instr : 16'h0000;
      flush    <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (issue && is_br) state_q <= StBrWait;
        end
        StBrWait: begin
          if (ex_resolve) begin
            if (ex_taken) begin
              state_q <= StFlush;
              flush   <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StFlush: state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef ISSUE_STALL_COUNTER_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else if (if_valid && !if_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/issue_sequencer.md
Name: issue_sequencer

Overview:
- Sits between instruction fetch and the decode/control stage of the pipelined processor.
- Accepts instructions from fetch over a valid/ready handshake and issues them one per cycle into decode.
- Stalls issue on register or flag read-after-write hazards (per-register countdown scoreboard) and on a busy data memory.
- Serialises BEQ/JMP: holds issue until the execute stage resolves the branch, then flushes fetch when it is taken.

Parameters:
- NREG, 16, number of architectural registers; register fields are 4 bits wide.
- ALU_LAT, 2, cycles from ALU-op issue until a dependent may issue (min 1).
- LD_LAT, 3, cycles from LD/RES issue until a dependent may issue (min 1).
- CNT_W, 2, scoreboard counter width; must hold max(ALU_LAT, LD_LAT)-1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
- if_ready  out  1  sequencer accepts this cycle (combinational)
- id_valid  out  1  registered: id_instr is a real instruction
- id_instr  out  16  registered instruction to decode; 16'h0000 (NOP) when id_valid=0
- mem_busy  in  1  data memory cannot take LD/ST this cycle
- ex_resolve  in  1  one-cycle pulse: branch resolved in execute
- ex_taken  in  1  qualified by ex_resolve; 1 = branch taken
- flush  out  1  registered one-cycle pulse to fetch: discard the fetched stream
- stall_cnt  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - id_valid=0, id_instr=0, flush=0, stall_cnt=0.
  - All scoreboard counters cleared; state=RUN.
  - Mid-operation reset drops any pending branch or hazard immediately.
- Opcode classes:
  - ALU-write rd: ADD 0001, MUL 0010, INC 0011, XOR 0100.
  - CMP 0110 reads rs1 and rs2 and writes the flag.
  - LD 1101: reads rs1, writes rd. RES 1100: writes rd. Both use LD_LAT.
  - ST 1010 reads rd and rs1.
  - BEQ 1011 reads the flag.
  - JMP 1111 reads nothing.
  - NOP 0000 and undefined opcodes read nothing, write nothing and pass through.
- Scoreboard:
  - One CNT_W counter per register plus one for the flag.
  - On issue, the destination counter loads LAT-1.
  - Otherwise every nonzero counter decrements by 1 each cycle, saturating at 0.
  - Issue-load overrides decrement in the same cycle.
  - A hazard exists if any source counter of if_instr is nonzero.
  - Net effect: a dependent issues LAT cycles after its producer; LAT=1 allows back-to-back issue.
- if_ready = (state==RUN) and no hazard and not (if_instr is LD/ST and mem_busy).
- Issue = if_valid and if_ready. Next cycle: id_valid=1, id_instr=if_instr. Otherwise id_valid=0, id_instr=0 (bubble).
- States:
  - RUN: issuing BEQ or JMP moves to BR_WAIT.
  - BR_WAIT: if_ready=0. On ex_resolve: ex_taken=1 goes to FLUSH; ex_taken=0 goes to RUN. No accept occurs in the resolve cycle.
  - FLUSH: flush=1 for exactly one cycle, if_ready=0, then RUN.
  - ex_resolve outside BR_WAIT is ignored.
- The scoreboard keeps counting in every state; counters are not cleared by flush.

Optional Feature:
- Macro: ISSUE_STALL_COUNTER_EN.
- With the macro:
  - stall_cnt increments by 1 on every cycle where if_valid=1 and if_ready=0.
  - It saturates at 16'hFFFF and clears only on reset.
- Without the macro: stall_cnt is tied to 16'h0000 and no counter logic exists.

Test Plan:
- Dependent ALU ops:
  - Stimulus: ADD r1,r2,r3 issues at cycle t; next if_instr = XOR r4,r1,r5 is held valid.
  - Required: if_ready=0 at t+1; XOR issues at t+2 (ALU_LAT=2); id_instr bubbles to 0 for one cycle; stall_cnt=1 with the macro.
- Load-use and memory busy:
  - LD r6 at cycle t, then ADD r7,r6,r0 → ADD issues at t+3.
  - ST presented with mem_busy=1 for 4 cycles → ST issues on the cycle mem_busy falls; stall_cnt advances by 4.
- Branch not taken:
  - Stimulus: CMP then BEQ; BEQ waits 2 cycles on the flag, issues, then state=BR_WAIT; ex_resolve=1, ex_taken=0 after 3 cycles.
  - Required: if_ready=0 throughout the wait; flush stays 0; next instruction accepted one cycle after the resolve cycle.
- Taken jump:
  - Stimulus: JMP issues; ex_resolve=1, ex_taken=1.
  - Required: flush=1 for exactly one cycle after resolve; if_ready=0 that cycle; RUN on the following cycle.
- Reset mid-branch:
  - Stimulus: assert rst_n=0 asynchronously between clock edges while in BR_WAIT with the r1 counter nonzero.
  - Required: outputs zero immediately; after release, ADD r2,r1,r1 issues on the first valid cycle.
- Back-to-back independent ops:
  - Stimulus: 8 independent ALU ops with continuous if_valid.
  - Required: 8 consecutive id_valid=1 cycles; stall_cnt unchanged.
